// File: rtl/mult_div_pkg.sv
// Shared definitions for the mult/div sequencer slice.
// Holds the default operand width, the op-select encoding used on the
// request bus, and the sequencer state encoding.
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // op select carried with start
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CALC    = 3'd2,
    ST_RESULT  = 3'd3,
    ST_DIVZERO = 3'd4
  } state_t;

endpackage

// File: rtl/mult_div_sequencer_if.sv
// Request/response bus between the main control unit and the mult/div
// sequencer.
//   start, op, rs_data, rt_data : request from the control unit (master)
//   busy, done, div0            : status back from the sequencer (slave)
//   hi, lo                      : HI/LO registers, read directly by mfhi/mflo
interface mult_div_sequencer_if
  import mult_div_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, div0, hi, lo
  );

endinterface

// File: rtl/mult_div_engine.sv
// Iterative unsigned mult/div engine, one iteration per step.
//   clock, reset        : clock and synchronous active-high reset
//   load                : capture operand magnitudes, clear accumulator
//   step                : perform one shift-add or restoring-divide iteration
//   op                  : OP_MULT or OP_DIV
//   rs_mag, rt_mag      : operand magnitudes
//   product             : {acc, multiplier} after WIDTH mult steps
//   quotient, remainder : results after WIDTH div steps
module mult_div_engine
  import mult_div_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               op,
  input  logic [WIDTH-1:0]   rs_mag,
  input  logic [WIDTH-1:0]   rt_mag,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  // a_reg holds the multiplicand (mult) or divisor (div).
  // b_reg holds the multiplier (mult) or the dividend shifting into the
  // quotient (div). acc_reg is the upper product half or the remainder.
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg;
  logic [WIDTH-1:0] acc_next, b_next;
  logic [WIDTH:0]   add_sum, shifted_rem, trial_diff;

  // Single-iteration datapath. The extra top bit of add_sum is the carry
  // that shifts into the accumulator; the top bit of trial_diff is the
  // borrow that decides whether the restoring subtract is kept.
  always_comb begin
    add_sum     = {1'b0, acc_reg} + (b_reg[0] ? {1'b0, a_reg} : '0);
    shifted_rem = {acc_reg, b_reg[WIDTH-1]};
    trial_diff  = shifted_rem - {1'b0, a_reg};
    if (op == OP_DIV) begin
      if (!trial_diff[WIDTH]) begin
        acc_next = trial_diff[WIDTH-1:0];
        b_next   = {b_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted_rem[WIDTH-1:0];
        b_next   = {b_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = add_sum[WIDTH:1];
      b_next   = {add_sum[0], b_reg[WIDTH-1:1]};
    end
  end

  // Operand/accumulator registers: load sets up the magnitudes, step
  // advances one iteration, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else if (load) begin
      a_reg   <= (op == OP_DIV) ? rt_mag : rs_mag;
      b_reg   <= (op == OP_DIV) ? rs_mag : rt_mag;
      acc_reg <= '0;
    end else if (step) begin
      acc_reg <= acc_next;
      b_reg   <= b_next;
    end
  end

  assign product   = {acc_reg, b_reg};
  assign quotient  = b_reg;
  assign remainder = acc_reg;

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle controller for MIPS mult/div: FSM, iteration counter, sign
// tracking and fix-up, and the HI/LO registers.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : start/op/rs_data/rt_data in; busy/done/div0/hi/lo out
module mult_div_sequencer
  import mult_div_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH) (
  input logic                  clock,
  input logic                  reset,
  mult_div_sequencer_if.slave  bus
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t             state, next_state;
  logic               busy_q, done_q, div0_q;
  logic               busy_next, done_next, div0_next;
  logic               accept, eng_load, eng_step;
  logic               op_q, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_q, rt_q, hi_q, lo_q;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   rs_mag, rt_mag, quotient, remainder;
  logic [2*WIDTH-1:0] product, product_fix;

  mult_div_engine #(.WIDTH(WIDTH)) engine (
    .clock     (clock),
    .reset     (reset),
    .load      (eng_load),
    .step      (eng_step),
    .op        (op_q),
    .rs_mag    (rs_mag),
    .rt_mag    (rt_mag),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Next-state and control decode. busy follows whether the next state is
  // non-idle, so it drops on the same edge that raises done or div0.
  always_comb begin
    next_state = state;
    done_next  = 1'b0;
    div0_next  = 1'b0;
    eng_load   = 1'b0;
    eng_step   = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_DIV && bus.rt_data == '0) begin
            next_state = ST_DIVZERO;
          end else begin
            next_state = ST_LOAD;
            accept     = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        eng_load   = 1'b1;
        next_state = ST_CALC;
      end
      ST_CALC: begin
        eng_step = 1'b1;
        if (count == LAST_ITER) next_state = ST_RESULT;
      end
      ST_RESULT: begin
        done_next  = 1'b1;
        next_state = ST_IDLE;
      end
      ST_DIVZERO: begin
        div0_next  = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    busy_next = (next_state != ST_IDLE);
  end

  // State and registered status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= busy_next;
      done_q <= done_next;
      div0_q <= div0_next;
    end
  end

  // Operand latch, iteration counter and HI/LO update. Operands are
  // captured on the accepting edge so later bus changes cannot disturb the
  // running operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q   <= OP_MULT;
      rs_q   <= '0;
      rt_q   <= '0;
      rs_neg <= 1'b0;
      rt_neg <= 1'b0;
      count  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (accept) begin
        op_q   <= bus.op;
        rs_q   <= bus.rs_data;
        rt_q   <= bus.rt_data;
        rs_neg <= bus.rs_data[WIDTH-1];
        rt_neg <= bus.rt_data[WIDTH-1];
      end
      if (eng_load) count <= '0;
      else if (eng_step) count <= count + 1'b1;
      if (state == ST_RESULT) begin
        if (op_q == OP_DIV) begin
          lo_q <= (rs_neg ^ rt_neg) ? -quotient : quotient;
          hi_q <= rs_neg ? -remainder : remainder;
        end else begin
          {hi_q, lo_q} <= product_fix;
        end
      end
    end
  end

  // Magnitudes for the engine and the signed product fix-up. Negating the
  // most negative value yields itself, which reads correctly as unsigned.
  assign rs_mag      = rs_neg ? -rs_q : rs_q;
  assign rt_mag      = rt_neg ? -rt_q : rt_q;
  assign product_fix = (rs_neg ^ rt_neg) ? -product : product;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: signed mult/div, divide by zero,
// extreme operands, start while busy and reset mid-operation.
module tb_mult_div_sequencer;
  import mult_div_pkg::*;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   kEdge;

  mult_div_sequencer_if #(.WIDTH(32)) bus ();

  mult_div_sequencer #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // free-running edge counter used to measure latency
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one edge, record the accepting edge, then scramble the
  // data inputs so operand latching is exercised.
  task automatic applyStimulus(input logic opSel, input logic [31:0] rs,
                               input logic [31:0] rt);
    @(negedge clock);
    bus.start   = 1'b1;
    bus.op      = opSel;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(posedge clock);
    #1;
    kEdge       = cyc;
    bus.start   = 1'b0;
    bus.rs_data = ~rs;
    bus.rt_data = 32'h0;
    checkOutput("busy_on_accept", {63'd0, bus.busy}, 64'd1);
  endtask

  // Wait (bounded) for done or div0; latency is in edges since acceptance.
  task automatic waitResult(output int latency);
    int n;
    n = 0;
    while (n < 60 && !bus.done && !bus.div0) begin
      @(posedge clock);
      #1;
      n++;
    end
    latency = cyc - kEdge;
  endtask

  task automatic runAndCheck(input string tag, input logic opSel,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] expHi, input logic [31:0] expLo);
    int lat;
    applyStimulus(opSel, rs, rt);
    waitResult(lat);
    checkOutput({tag, "_lat"},  lat, 64'd34);
    checkOutput({tag, "_done"}, {63'd0, bus.done}, 64'd1);
    checkOutput({tag, "_div0"}, {63'd0, bus.div0}, 64'd0);
    checkOutput({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    checkOutput({tag, "_hi"},   {32'd0, bus.hi}, {32'd0, expHi});
    checkOutput({tag, "_lo"},   {32'd0, bus.lo}, {32'd0, expLo});
  endtask

  initial begin
    int lat;
    int doneSeen;
    total       = 0;
    bad         = 0;
    cyc         = 0;
    kEdge       = 0;
    bus.start   = 1'b0;
    bus.op      = OP_MULT;
    bus.rs_data = '0;
    bus.rt_data = '0;
    reset       = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("rst_done", {63'd0, bus.done}, 64'd0);
    checkOutput("rst_div0", {63'd0, bus.div0}, 64'd0);
    checkOutput("rst_hi",   {32'd0, bus.hi}, 64'd0);
    checkOutput("rst_lo",   {32'd0, bus.lo}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // 7 * -3 = -21
    runAndCheck("mul_neg", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(posedge clock); #1;
    checkOutput("mul_neg_done_pulse", {63'd0, bus.done}, 64'd0);

    // -7 / 2 = -3 rem -1, started the cycle after the previous done
    runAndCheck("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(posedge clock); #1;
    checkOutput("div_neg_done_pulse", {63'd0, bus.done}, 64'd0);

    // 100 / 7 = 14 rem 2; 7 / -2 = -3 rem 1
    runAndCheck("div_pos", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14);
    runAndCheck("div_mix", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    // preload HI/LO then divide by zero
    runAndCheck("mul_3x5", OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15);
    applyStimulus(OP_DIV, 32'd5, 32'd0);
    waitResult(lat);
    checkOutput("dz_lat",  lat, 64'd1);
    checkOutput("dz_div0", {63'd0, bus.div0}, 64'd1);
    checkOutput("dz_done", {63'd0, bus.done}, 64'd0);
    checkOutput("dz_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("dz_hi",   {32'd0, bus.hi}, 64'd0);
    checkOutput("dz_lo",   {32'd0, bus.lo}, 64'd15);
    @(posedge clock); #1;
    checkOutput("dz_div0_pulse", {63'd0, bus.div0}, 64'd0);

    // extremes
    runAndCheck("mul_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    runAndCheck("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // start while busy is ignored
    applyStimulus(OP_MULT, 32'd2, 32'd3);
    repeat (9) @(posedge clock);
    @(negedge clock);
    bus.start   = 1'b1;
    bus.op      = OP_DIV;
    bus.rs_data = 32'd9;
    bus.rt_data = 32'd0;
    @(posedge clock); #1;
    bus.start = 1'b0;
    checkOutput("busy_ign_busy", {63'd0, bus.busy}, 64'd1);
    waitResult(lat);
    checkOutput("busy_ign_lat",  lat, 64'd34);
    checkOutput("busy_ign_done", {63'd0, bus.done}, 64'd1);
    checkOutput("busy_ign_div0", {63'd0, bus.div0}, 64'd0);
    checkOutput("busy_ign_hi",   {32'd0, bus.hi}, 64'd0);
    checkOutput("busy_ign_lo",   {32'd0, bus.lo}, 64'd6);

    // reset during CALC aborts
    applyStimulus(OP_MULT, 32'd7, 32'd9);
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("rst_mid_hi",   {32'd0, bus.hi}, 64'd0);
    checkOutput("rst_mid_lo",   {32'd0, bus.lo}, 64'd0);
    checkOutput("rst_mid_done", {63'd0, bus.done}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done || bus.div0) doneSeen++;
    end
    checkOutput("rst_mid_no_done", doneSeen, 64'd0);
    runAndCheck("mul_4x4", OP_MULT, 32'd4, 32'd4, 32'd0, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
